// File: rtl/aes_sub_bytes_if.sv
`default_nettype none
// ============================================================================
//  Module   : aes_sub_bytes_if
//  Purpose  : Block-in / block-out bus for the registered AES SubBytes stage.
//             The master drives a 128-bit state block with a valid flag and
//             receives the substituted block with its own valid flag.
//  Revision : 1.0  initial release
// ============================================================================
interface aes_sub_bytes_if;
    logic         in_valid;
    logic [127:0] bloco;
    logic         out_valid;
    logic [127:0] saida;

    // Upstream side: presents blocks, consumes results
    modport master (
        output in_valid,
        output bloco,
        input  out_valid,
        input  saida
    );

    // SubBytes stage side
    modport slave (
        input  in_valid,
        input  bloco,
        output out_valid,
        output saida
    );
endinterface
`default_nettype wire

// File: rtl/aes_sub_bytes.sv
`default_nettype none
// ============================================================================
//  Module   : aes_sub_bytes
//  Purpose  : Registered AES SubBytes stage. Each of the 16 byte lanes of the
//             input block is replaced by its forward S-box value; the result
//             is captured one clock after a valid input. One block per clock,
//             no backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module aes_sub_bytes (
    input  wire logic      clk,
    input  wire logic      rst,
    aes_sub_bytes_if.slave bus
);

    localparam int c_LANES = 16;

    // Forward AES S-box, full 256-entry lookup table
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        case (b)
            8'h00: r = 8'h63;  8'h01: r = 8'h7c;  8'h02: r = 8'h77;  8'h03: r = 8'h7b;
            8'h04: r = 8'hf2;  8'h05: r = 8'h6b;  8'h06: r = 8'h6f;  8'h07: r = 8'hc5;
            8'h08: r = 8'h30;  8'h09: r = 8'h01;  8'h0a: r = 8'h67;  8'h0b: r = 8'h2b;
            8'h0c: r = 8'hfe;  8'h0d: r = 8'hd7;  8'h0e: r = 8'hab;  8'h0f: r = 8'h76;
            8'h10: r = 8'hca;  8'h11: r = 8'h82;  8'h12: r = 8'hc9;  8'h13: r = 8'h7d;
            8'h14: r = 8'hfa;  8'h15: r = 8'h59;  8'h16: r = 8'h47;  8'h17: r = 8'hf0;
            8'h18: r = 8'had;  8'h19: r = 8'hd4;  8'h1a: r = 8'ha2;  8'h1b: r = 8'haf;
            8'h1c: r = 8'h9c;  8'h1d: r = 8'ha4;  8'h1e: r = 8'h72;  8'h1f: r = 8'hc0;
            8'h20: r = 8'hb7;  8'h21: r = 8'hfd;  8'h22: r = 8'h93;  8'h23: r = 8'h26;
            8'h24: r = 8'h36;  8'h25: r = 8'h3f;  8'h26: r = 8'hf7;  8'h27: r = 8'hcc;
            8'h28: r = 8'h34;  8'h29: r = 8'ha5;  8'h2a: r = 8'he5;  8'h2b: r = 8'hf1;
            8'h2c: r = 8'h71;  8'h2d: r = 8'hd8;  8'h2e: r = 8'h31;  8'h2f: r = 8'h15;
            8'h30: r = 8'h04;  8'h31: r = 8'hc7;  8'h32: r = 8'h23;  8'h33: r = 8'hc3;
            8'h34: r = 8'h18;  8'h35: r = 8'h96;  8'h36: r = 8'h05;  8'h37: r = 8'h9a;
            8'h38: r = 8'h07;  8'h39: r = 8'h12;  8'h3a: r = 8'h80;  8'h3b: r = 8'he2;
            8'h3c: r = 8'heb;  8'h3d: r = 8'h27;  8'h3e: r = 8'hb2;  8'h3f: r = 8'h75;
            8'h40: r = 8'h09;  8'h41: r = 8'h83;  8'h42: r = 8'h2c;  8'h43: r = 8'h1a;
            8'h44: r = 8'h1b;  8'h45: r = 8'h6e;  8'h46: r = 8'h5a;  8'h47: r = 8'ha0;
            8'h48: r = 8'h52;  8'h49: r = 8'h3b;  8'h4a: r = 8'hd6;  8'h4b: r = 8'hb3;
            8'h4c: r = 8'h29;  8'h4d: r = 8'he3;  8'h4e: r = 8'h2f;  8'h4f: r = 8'h84;
            8'h50: r = 8'h53;  8'h51: r = 8'hd1;  8'h52: r = 8'h00;  8'h53: r = 8'hed;
            8'h54: r = 8'h20;  8'h55: r = 8'hfc;  8'h56: r = 8'hb1;  8'h57: r = 8'h5b;
            8'h58: r = 8'h6a;  8'h59: r = 8'hcb;  8'h5a: r = 8'hbe;  8'h5b: r = 8'h39;
            8'h5c: r = 8'h4a;  8'h5d: r = 8'h4c;  8'h5e: r = 8'h58;  8'h5f: r = 8'hcf;
            8'h60: r = 8'hd0;  8'h61: r = 8'hef;  8'h62: r = 8'haa;  8'h63: r = 8'hfb;
            8'h64: r = 8'h43;  8'h65: r = 8'h4d;  8'h66: r = 8'h33;  8'h67: r = 8'h85;
            8'h68: r = 8'h45;  8'h69: r = 8'hf9;  8'h6a: r = 8'h02;  8'h6b: r = 8'h7f;
            8'h6c: r = 8'h50;  8'h6d: r = 8'h3c;  8'h6e: r = 8'h9f;  8'h6f: r = 8'ha8;
            8'h70: r = 8'h51;  8'h71: r = 8'ha3;  8'h72: r = 8'h40;  8'h73: r = 8'h8f;
            8'h74: r = 8'h92;  8'h75: r = 8'h9d;  8'h76: r = 8'h38;  8'h77: r = 8'hf5;
            8'h78: r = 8'hbc;  8'h79: r = 8'hb6;  8'h7a: r = 8'hda;  8'h7b: r = 8'h21;
            8'h7c: r = 8'h10;  8'h7d: r = 8'hff;  8'h7e: r = 8'hf3;  8'h7f: r = 8'hd2;
            8'h80: r = 8'hcd;  8'h81: r = 8'h0c;  8'h82: r = 8'h13;  8'h83: r = 8'hec;
            8'h84: r = 8'h5f;  8'h85: r = 8'h97;  8'h86: r = 8'h44;  8'h87: r = 8'h17;
            8'h88: r = 8'hc4;  8'h89: r = 8'ha7;  8'h8a: r = 8'h7e;  8'h8b: r = 8'h3d;
            8'h8c: r = 8'h64;  8'h8d: r = 8'h5d;  8'h8e: r = 8'h19;  8'h8f: r = 8'h73;
            8'h90: r = 8'h60;  8'h91: r = 8'h81;  8'h92: r = 8'h4f;  8'h93: r = 8'hdc;
            8'h94: r = 8'h22;  8'h95: r = 8'h2a;  8'h96: r = 8'h90;  8'h97: r = 8'h88;
            8'h98: r = 8'h46;  8'h99: r = 8'hee;  8'h9a: r = 8'hb8;  8'h9b: r = 8'h14;
            8'h9c: r = 8'hde;  8'h9d: r = 8'h5e;  8'h9e: r = 8'h0b;  8'h9f: r = 8'hdb;
            8'ha0: r = 8'he0;  8'ha1: r = 8'h32;  8'ha2: r = 8'h3a;  8'ha3: r = 8'h0a;
            8'ha4: r = 8'h49;  8'ha5: r = 8'h06;  8'ha6: r = 8'h24;  8'ha7: r = 8'h5c;
            8'ha8: r = 8'hc2;  8'ha9: r = 8'hd3;  8'haa: r = 8'hac;  8'hab: r = 8'h62;
            8'hac: r = 8'h91;  8'had: r = 8'h95;  8'hae: r = 8'he4;  8'haf: r = 8'h79;
            8'hb0: r = 8'he7;  8'hb1: r = 8'hc8;  8'hb2: r = 8'h37;  8'hb3: r = 8'h6d;
            8'hb4: r = 8'h8d;  8'hb5: r = 8'hd5;  8'hb6: r = 8'h4e;  8'hb7: r = 8'ha9;
            8'hb8: r = 8'h6c;  8'hb9: r = 8'h56;  8'hba: r = 8'hf4;  8'hbb: r = 8'hea;
            8'hbc: r = 8'h65;  8'hbd: r = 8'h7a;  8'hbe: r = 8'hae;  8'hbf: r = 8'h08;
            8'hc0: r = 8'hba;  8'hc1: r = 8'h78;  8'hc2: r = 8'h25;  8'hc3: r = 8'h2e;
            8'hc4: r = 8'h1c;  8'hc5: r = 8'ha6;  8'hc6: r = 8'hb4;  8'hc7: r = 8'hc6;
            8'hc8: r = 8'he8;  8'hc9: r = 8'hdd;  8'hca: r = 8'h74;  8'hcb: r = 8'h1f;
            8'hcc: r = 8'h4b;  8'hcd: r = 8'hbd;  8'hce: r = 8'h8b;  8'hcf: r = 8'h8a;
            8'hd0: r = 8'h70;  8'hd1: r = 8'h3e;  8'hd2: r = 8'hb5;  8'hd3: r = 8'h66;
            8'hd4: r = 8'h48;  8'hd5: r = 8'h03;  8'hd6: r = 8'hf6;  8'hd7: r = 8'h0e;
            8'hd8: r = 8'h61;  8'hd9: r = 8'h35;  8'hda: r = 8'h57;  8'hdb: r = 8'hb9;
            8'hdc: r = 8'h86;  8'hdd: r = 8'hc1;  8'hde: r = 8'h1d;  8'hdf: r = 8'h9e;
            8'he0: r = 8'he1;  8'he1: r = 8'hf8;  8'he2: r = 8'h98;  8'he3: r = 8'h11;
            8'he4: r = 8'h69;  8'he5: r = 8'hd9;  8'he6: r = 8'h8e;  8'he7: r = 8'h94;
            8'he8: r = 8'h9b;  8'he9: r = 8'h1e;  8'hea: r = 8'h87;  8'heb: r = 8'he9;
            8'hec: r = 8'hce;  8'hed: r = 8'h55;  8'hee: r = 8'h28;  8'hef: r = 8'hdf;
            8'hf0: r = 8'h8c;  8'hf1: r = 8'ha1;  8'hf2: r = 8'h89;  8'hf3: r = 8'h0d;
            8'hf4: r = 8'hbf;  8'hf5: r = 8'he6;  8'hf6: r = 8'h42;  8'hf7: r = 8'h68;
            8'hf8: r = 8'h41;  8'hf9: r = 8'h99;  8'hfa: r = 8'h2d;  8'hfb: r = 8'h0f;
            8'hfc: r = 8'hb0;  8'hfd: r = 8'h54;  8'hfe: r = 8'hbb;  8'hff: r = 8'h16;
        endcase
        return r;
    endfunction

    logic [127:0] w_sub;
    logic [127:0] r_saida;
    logic         r_valid;

    // One independent S-box per byte lane; lane k in maps to lane k out
    generate
        for (genvar k = 0; k < c_LANES; k++) begin : g_lane
            assign w_sub[8*k +: 8] = sbox(bus.bloco[8*k +: 8]);
        end
    endgenerate

    // Output register: capture only on valid so bloco is ignored (including X)
    // when idle; the valid flag simply follows in_valid by one clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_saida <= 128'h0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_saida <= w_sub;
            end
        end
    end

    assign bus.saida     = r_saida;
    assign bus.out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_aes_sub_bytes.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes_sub_bytes
//  Purpose  : Scoreboard bench for aes_sub_bytes. Expected blocks come from a
//             GF(2^8) inverse + affine-transform model of the AES S-box or
//             from published test vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_sub_bytes;

    logic clk;
    logic rst;

    aes_sub_bytes_if bus ();

    aes_sub_bytes dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           checks;
    int           errors;
    logic [127:0] exp_q[$];
    logic [127:0] last_out;
    logic [7:0]   sbox_ref[256];

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox_ref[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
                          ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] ref_block(input logic [127:0] blk);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_ref[blk[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample mid-cycle; pop on every valid output, else expect hold
    always @(negedge clk) begin
        if (rst) begin
            check("reset_saida", bus.saida, 128'h0);
            check("reset_valid", {127'h0, bus.out_valid}, 128'h0);
        end else if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 128'h1, 128'h0);
            end else begin
                last_out = exp_q.pop_front();
                check("saida", bus.saida, last_out);
            end
        end else begin
            check("hold", bus.saida, last_out);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [127:0] blk, input logic use_exp,
                         input logic [127:0] exp_blk);
        @(negedge clk);
        bus.in_valid = v;
        bus.bloco    = blk;
        if (v && !rst) exp_q.push_back(use_exp ? exp_blk : ref_block(blk));
    endtask

    task automatic send(input logic [127:0] blk);
        drive(1'b1, blk, 1'b0, 128'h0);
    endtask

    task automatic send_vec(input logic [127:0] blk, input logic [127:0] exp_blk);
        drive(1'b1, blk, 1'b1, exp_blk);
    endtask

    task automatic idle();
        drive(1'b0, rand128(), 1'b0, 128'h0);
    endtask

    // Assert reset between edges, verify immediate clearing, offer a block
    // during reset, then release
    task automatic mid_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        last_out = 128'h0;
        #1;
        check("async_reset_saida", bus.saida, 128'h0);
        check("async_reset_valid", {127'h0, bus.out_valid}, 128'h0);
        send(rand128());
        @(posedge clk);
        idle();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    logic [127:0] va;
    logic [127:0] vb;

    initial begin
        checks       = 0;
        errors       = 0;
        last_out     = 128'h0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.bloco    = 128'h0;
        build_sbox();

        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        // Published vectors
        send_vec(128'h50414c41565241544553544543494652, 128'h53832983b10083206eed206e1a3b5a00);
        send_vec(128'h0, {16{8'h63}});
        send_vec({16{8'hff}}, {16{8'h16}});
        send_vec(128'h193de3be_a0f4e22b_9ac68d2a_e9f84808, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230);

        // Streaming then hold with random idle data
        va = rand128();
        vb = rand128();
        send(va);
        send(vb);
        repeat (3) idle();

        // Reset mid-stream with a nonzero output register
        send(rand128());
        send(rand128());
        mid_reset();
        repeat (2) idle();

        // Exhaustive S-box sweep, each byte replicated across all lanes
        for (int b = 0; b < 256; b++) send({16{8'(b)}});
        repeat (2) idle();

        // Random traffic with random gaps
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) != 0) send(rand128());
            else idle();
        end
        repeat (4) idle();

        check("drain", 128'(exp_q.size()), 128'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes_sub_bytes.md
Name: aes_sub_bytes

Overview:
Registered AES SubBytes stage for the cipher datapath.
- Replaces each of the 16 bytes of a 128-bit state block with its FIPS-197 forward S-box value.
- Captures the substituted block in an output register one clock after a valid input.
- Sits between AddRoundKey and ShiftRows in the round pipeline.

Parameters:
None. Block width is fixed at 128 bits (16 bytes); the S-box is fixed to the AES forward S-box.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  bloco holds a block to substitute this cycle
bloco  input  128  input state block; byte k = bloco[8k+7:8k], k=0..15
out_valid  output  1  saida holds a freshly substituted block
saida  output  128  substituted block; saida[8k+7:8k] = SBOX(bloco[8k+7:8k])

Behaviour:
- Reset is asynchronous and active-high.
  - While rst=1: saida=128'h0 and out_valid=0, immediately and independent of clk.
  - First capture after rst deasserts happens on the first rising clk edge with in_valid=1.
- Datapath:
  - 16 identical, independent combinational S-box lookups, one per byte lane.
  - No inter-byte interaction.
  - Byte ordering is preserved: lane k in maps to lane k out.
- S-box:
  - Full 256-entry AES forward S-box (FIPS-197 Fig. 7), implemented as a combinational lookup function or case table.
  - Anchor values: S(00)=63, S(01)=7c, S(19)=d4, S(3d)=27, S(41)=83, S(50)=53, S(52)=00, S(53)=ed, S(be)=ae, S(e3)=11, S(ff)=16.
- Timing: latency 1 clock.
  - Rising edge with in_valid=1: saida <= SBOX applied bytewise to bloco; out_valid <= 1.
  - Rising edge with in_valid=0: saida holds its previous value; out_valid <= 0.
- Throughput: one block per clock. Back-to-back in_valid cycles produce back-to-back out_valid cycles, each with its own block.
- No backpressure, no ready signal; the downstream stage must accept on out_valid.
- Reset mid-stream: any block captured or in flight is discarded. Outputs go to zero/0 at once. A block presented during reset is not captured.
- bloco contents are don't-care when in_valid=0. X on bloco with in_valid=0 must not propagate to saida.

Test Plan:
- Reset: assert rst asynchronously between clock edges with saida nonzero -> saida=0 and out_valid=0 immediately, before the next edge.
- Text block: bloco=128'h50414c41565241544553544543494652 with in_valid=1 -> one edge later saida=128'h53832983b10083206eed206e1a3b5a00, out_valid=1.
- Uniform blocks:
  - all-zero block -> saida=128'h63636363636363636363636363636363
  - all-FF block -> saida=128'h16161616161616161616161616161616
- FIPS-197 lanes: bloco=128'h193de3be_a0f4e22b_9ac68d2a_e9f84808 -> saida=128'hd42711ae_e0bf98f1_b8b45de5_1e415230.
- Streaming and hold: vector A, then vector B on consecutive cycles with in_valid=1, then in_valid=0 for 3 cycles with random bloco ->
  - saida shows SBOX(A), then SBOX(B) on consecutive edges;
  - out_valid=1 for exactly those 2 cycles, then 0;
  - saida holds SBOX(B) unchanged.
- Exhaustive S-box: sweep all 256 byte values replicated across all 16 lanes -> every lane matches the FIPS-197 table entry.
